dcache_tag_lookup: RTL and testbench

DCACHE_TAG_LOOKUP -- requirements
Module: dcache_tag_lookup

---
 rtl/dcache_tag_lookup.sv | 154 +++++++++++++++
 tb/tb_dcache_tag_lookup.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_tag_lookup.sv
// dcache_tag_lookup: 8-way tag compare over an external 64-set tag array, two-stage read pipeline.
// Optional hit/miss counters are built when DCACHE_TAG_LOOKUP_PERF_EN is defined.
module dcache_tag_lookup #(
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [5:0]       req_idx,
    input  logic [20:0]      req_tag,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic             resp_hit,
    output logic [2:0]       resp_way,
    output logic [1:0]       resp_state,
    output logic             resp_multi_hit,
    output logic             resp_inv_valid,
    output logic [2:0]       resp_inv_way,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [5:0]       wr_idx,
    input  logic [2:0]       wr_way,
    input  logic [20:0]      wr_tag,
    input  logic [1:0]       wr_state,
    output logic [5:0]       arr_R0_addr,
    output logic             arr_R0_en,
    input  logic [183:0]     arr_R0_data,
    output logic [5:0]       arr_W0_addr,
    output logic             arr_W0_en,
    output logic [183:0]     arr_W0_data,
    output logic [7:0]       arr_W0_mask,
    output logic [CNT_W-1:0] perf_hits,
    output logic [CNT_W-1:0] perf_misses
);
    localparam int WAYS   = 8;
    localparam int LANE_W = 23;

    typedef struct packed {
        logic       hit;
        logic [2:0] way;
        logic [1:0] state;
        logic       multi;
        logic       inv_valid;
        logic [2:0] inv_way;
    } res_t;

    logic            s1_valid_q, s1_valid_d;
    logic [5:0]      s1_idx_q, s1_idx_d;
    logic [20:0]     s1_tag_q, s1_tag_d;
    logic            s2_valid_q, s2_valid_d;
    res_t            s2_res_q, s2_res_d, lookup;
    logic            advance, replay, s1_move, req_fire, resp_fire;
    logic [WAYS-1:0] match, inv;

    assign advance   = !s2_valid_q || resp_ready;
    assign replay    = s1_valid_q && wr_valid && (wr_idx == s1_idx_q);
    assign s1_move   = s1_valid_q && advance && !replay;
    // A replay keeps S1 occupied, so a new request cannot be taken in that cycle either.
    assign req_ready = !reset && advance && !replay && !(wr_valid && (wr_idx == req_idx));
    assign req_fire  = req_valid && req_ready;
    assign resp_fire = resp_valid && resp_ready;

    assign arr_R0_en   = !reset && (req_fire || (s1_valid_q && !s1_move));
    assign arr_R0_addr = req_fire ? req_idx : s1_idx_q;

    assign wr_ready    = 1'b1;
    assign arr_W0_en   = wr_valid && !reset;
    assign arr_W0_addr = wr_idx;
    assign arr_W0_data = {WAYS{wr_tag, wr_state}};
    assign arr_W0_mask = 8'd1 << wr_way;

    // Scan high to low so the lowest qualifying way is the last one written.
    always_comb begin
        match  = '0;
        inv    = '0;
        lookup = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (arr_R0_data[w*LANE_W +: 2] == 2'd0) begin
                inv[w]         = 1'b1;
                lookup.inv_way = 3'(w);
            end else if (arr_R0_data[w*LANE_W+2 +: 21] == s1_tag_q) begin
                match[w]     = 1'b1;
                lookup.way   = 3'(w);
                lookup.state = arr_R0_data[w*LANE_W +: 2];
            end
        end
        lookup.hit       = |match;
        lookup.multi     = |(match & (match - 8'd1));
        lookup.inv_valid = |inv;
    end

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_idx_d   = s1_idx_q;
        s1_tag_d   = s1_tag_q;
        s2_valid_d = s2_valid_q;
        s2_res_d   = s2_res_q;
        if (req_fire) begin
            s1_valid_d = 1'b1;
            s1_idx_d   = req_idx;
            s1_tag_d   = req_tag;
        end else if (s1_move) begin
            s1_valid_d = 1'b0;
        end
        if (s1_move) begin
            s2_valid_d = 1'b1;
            s2_res_d   = lookup;
        end else if (resp_ready) begin
            s2_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s1_idx_q   <= '0;
            s1_tag_q   <= '0;
            s2_valid_q <= 1'b0;
            s2_res_q   <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_idx_q   <= s1_idx_d;
            s1_tag_q   <= s1_tag_d;
            s2_valid_q <= s2_valid_d;
            s2_res_q   <= s2_res_d;
        end
    end

    assign resp_valid = s2_valid_q && !reset;
    assign {resp_hit, resp_way, resp_state, resp_multi_hit, resp_inv_valid, resp_inv_way} =
        reset ? res_t'('0) : s2_res_q;

`ifdef DCACHE_TAG_LOOKUP_PERF_EN
    logic [CNT_W-1:0] hits_q, misses_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            hits_q   <= '0;
            misses_q <= '0;
        end else if (resp_fire) begin
            if (s2_res_q.hit) hits_q <= hits_q + CNT_W'(1);
            else              misses_q <= misses_q + CNT_W'(1);
        end
    end

    assign perf_hits   = hits_q;
    assign perf_misses = misses_q;
`else
    assign perf_hits   = '0;
    assign perf_misses = '0;
`endif

endmodule

// File: tb/tb_dcache_tag_lookup.sv
// Bench for dcache_tag_lookup: write-first tag RAM model, scoreboard of expected lookups, directed + random traffic.
module tb_dcache_tag_lookup;
    localparam int CNT_W = 16;

    typedef struct packed {
        logic       hit;
        logic [2:0] way;
        logic [1:0] state;
        logic       multi;
        logic       inv_valid;
        logic [2:0] inv_way;
    } res_t;

    logic             clock = 1'b0;
    logic             reset;
    logic             req_valid, req_ready;
    logic [5:0]       req_idx;
    logic [20:0]      req_tag;
    logic             resp_valid, resp_ready;
    logic             resp_hit, resp_multi_hit, resp_inv_valid;
    logic [2:0]       resp_way, resp_inv_way;
    logic [1:0]       resp_state;
    logic             wr_valid, wr_ready;
    logic [5:0]       wr_idx;
    logic [2:0]       wr_way;
    logic [20:0]      wr_tag;
    logic [1:0]       wr_state;
    logic [5:0]       arr_R0_addr, arr_W0_addr;
    logic             arr_R0_en, arr_W0_en;
    logic [183:0]     arr_R0_data, arr_W0_data;
    logic [7:0]       arr_W0_mask;
    logic [CNT_W-1:0] perf_hits, perf_misses;

    always #5 clock = ~clock;

    dcache_tag_lookup #(.CNT_W(CNT_W)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_idx(req_idx), .req_tag(req_tag),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_hit(resp_hit), .resp_way(resp_way),
        .resp_state(resp_state), .resp_multi_hit(resp_multi_hit), .resp_inv_valid(resp_inv_valid),
        .resp_inv_way(resp_inv_way),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_idx(wr_idx), .wr_way(wr_way),
        .wr_tag(wr_tag), .wr_state(wr_state),
        .arr_R0_addr(arr_R0_addr), .arr_R0_en(arr_R0_en), .arr_R0_data(arr_R0_data),
        .arr_W0_addr(arr_W0_addr), .arr_W0_en(arr_W0_en), .arr_W0_data(arr_W0_data),
        .arr_W0_mask(arr_W0_mask),
        .perf_hits(perf_hits), .perf_misses(perf_misses)
    );

    // Tag RAM: a write is visible to a read of the same set in the same cycle.
    logic        ram_clr;
    logic [22:0] ram [64][8];
    logic [183:0] rd_q;
    assign arr_R0_data = rd_q;

    always @(posedge clock) begin
        for (int w = 0; w < 8; w++) begin
            if (ram_clr) begin
                for (int i = 0; i < 64; i++) ram[i][w] <= '0;
            end else if (arr_W0_en && arr_W0_mask[w]) begin
                ram[arr_W0_addr][w] <= arr_W0_data[23*w +: 23];
            end
            if (arr_R0_en)
                rd_q[23*w +: 23] <= (arr_W0_en && arr_W0_mask[w] && arr_W0_addr == arr_R0_addr) ?
                                    arr_W0_data[23*w +: 23] : ram[arr_R0_addr][w];
        end
    end

    int checks = 0;
    int failures = 0;

    task automatic chk(string name, logic [63:0] got, logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // Reference model: the array contents as written by the bench, plus outstanding lookups.
    logic [22:0] ref_mem [64][8];
    logic [26:0] req_q[$];
    bit          have_cur;
    res_t        cur_exp;
    int          hit_cnt, miss_cnt, n_req;

    function automatic res_t mk(bit h, int w, int s, bit m, bit iv, int iw);
        res_t r;
        r.hit = h; r.way = 3'(w); r.state = 2'(s); r.multi = m; r.inv_valid = iv; r.inv_way = 3'(iw);
        return r;
    endfunction

    function automatic res_t expect_lookup(logic [5:0] idx, logic [20:0] tag);
        res_t r = '0;
        int hits[$];
        int invs[$];
        for (int w = 0; w < 8; w++) begin
            if (ref_mem[idx][w][1:0] == 2'd0) invs.push_back(w);
            else if (ref_mem[idx][w][22:2] == tag) hits.push_back(w);
        end
        r.hit = hits.size() > 0;
        r.multi = hits.size() > 1;
        if (r.hit) begin
            r.way = 3'(hits[0]);
            r.state = ref_mem[idx][hits[0]][1:0];
        end
        r.inv_valid = invs.size() > 0;
        if (r.inv_valid) r.inv_way = 3'(invs[0]);
        return r;
    endfunction

    function automatic res_t dut_res();
        res_t r;
        r.hit = resp_hit; r.way = resp_way; r.state = resp_state;
        r.multi = resp_multi_hit; r.inv_valid = resp_inv_valid; r.inv_way = resp_inv_way;
        return r;
    endfunction

    // Runs just before each rising edge with the cycle's inputs settled.
    task automatic mon();
        logic [26:0] e;
        if (reset) begin
            chk("rst_resp_valid", 64'(resp_valid), 64'd0);
            chk("rst_resp_fields", 64'(dut_res()), 64'd0);
            chk("rst_rd_en", 64'(arr_R0_en), 64'd0);
            chk("rst_wr_en", 64'(arr_W0_en), 64'd0);
            req_q.delete();
            have_cur = 0; hit_cnt = 0; miss_cnt = 0; n_req = 0;
            return;
        end
        chk("wr_ready", 64'(wr_ready), 64'd1);
        if (req_valid && wr_valid && req_idx == wr_idx)
            chk("req_ready_conflict", 64'(req_ready), 64'd0);
        if (resp_valid) begin
            if (!have_cur) begin
                chk("resp_outstanding", 64'(req_q.size() != 0), 64'd1);
                cur_exp = '0;
                if (req_q.size() != 0) begin
                    e = req_q.pop_front();
                    cur_exp = expect_lookup(e[26:21], e[20:0]);
                end
                have_cur = 1;
            end
            chk("resp", 64'(dut_res()), 64'(cur_exp));
            if (resp_ready) begin
                have_cur = 0;
                if (cur_exp.hit) hit_cnt++; else miss_cnt++;
            end
        end
        if (req_valid && req_ready) begin
            req_q.push_back({req_idx, req_tag});
            n_req++;
        end
        if (wr_valid) ref_mem[wr_idx][wr_way] = {wr_tag, wr_state};
    endtask

    task automatic step();
        #3;
        mon();
        @(negedge clock);
    endtask

    task automatic do_write(int idx, int way, logic [20:0] tag, int st);
        wr_valid = 1; wr_idx = 6'(idx); wr_way = 3'(way); wr_tag = tag; wr_state = 2'(st);
        step();
        wr_valid = 0;
    endtask

    task automatic look(string name, int idx, logic [20:0] tag, res_t exp);
        req_valid = 1; req_idx = 6'(idx); req_tag = tag;
        step();
        req_valid = 0;
        chk({name, "_lat1"}, 64'(resp_valid), 64'd0);
        step();
        chk({name, "_lat2"}, 64'(resp_valid), 64'd1);
        chk(name, 64'(dut_res()), 64'(exp));
        step();
    endtask

    task automatic drain();
        req_valid = 0; wr_valid = 0; resp_ready = 1;
        for (int i = 0; i < 20 && (req_q.size() > 0 || resp_valid); i++) step();
        chk("drain_empty", 64'(req_q.size() + int'(resp_valid)), 64'd0);
    endtask

    task automatic chk_perf(string name);
`ifdef DCACHE_TAG_LOOKUP_PERF_EN
        chk({name, "_hits"}, 64'(perf_hits), 64'(hit_cnt % (1 << CNT_W)));
        chk({name, "_misses"}, 64'(perf_misses), 64'(miss_cnt % (1 << CNT_W)));
`else
        chk({name, "_hits_off"}, 64'(perf_hits), 64'd0);
        chk({name, "_misses_off"}, 64'(perf_misses), 64'd0);
`endif
    endtask

    initial begin
        for (int i = 0; i < 64; i++)
            for (int w = 0; w < 8; w++) ref_mem[i][w] = '0;
        ram_clr = 1; reset = 1; resp_ready = 1;
        req_valid = 1; req_idx = 6'd3; req_tag = 21'h5;
        wr_valid = 1; wr_idx = 6'd3; wr_way = 3'd1; wr_tag = 21'h5; wr_state = 2'd1;
        @(negedge clock);
        repeat (3) step();
        ram_clr = 0; req_valid = 0; wr_valid = 0; reset = 0;
        #1;
        chk("rst_req_ready", 64'(req_ready), 64'd1);
        chk_perf("rst_perf");

        do_write(5, 3, 21'h1ABCD, 2);
        look("hit_way3", 5, 21'h1ABCD, mk(1, 3, 2, 0, 1, 0));
        look("miss_empty", 10, 21'h00001, mk(0, 0, 0, 0, 1, 0));

        // Request and write to the same set in one cycle.
        wr_valid = 1; wr_idx = 6'd9; wr_way = 3'd1; wr_tag = 21'h0F00D; wr_state = 2'd1;
        req_valid = 1; req_idx = 6'd9; req_tag = 21'h0F00D;
        #1 chk("wr_conflict_blocked", 64'(req_ready), 64'd0);
        step();
        wr_valid = 0;
        #1 chk("wr_conflict_next", 64'(req_ready), 64'd1);
        step();
        req_valid = 0;
        step();
        chk("wr_conflict_v", 64'(resp_valid), 64'd1);
        chk("wr_conflict_res", 64'(dut_res()), 64'(mk(1, 1, 1, 0, 1, 0)));
        step();

        // Write to the in-flight set one cycle after the request.
        req_valid = 1; req_idx = 6'd7; req_tag = 21'h00777;
        step();
        req_valid = 0;
        wr_valid = 1; wr_idx = 6'd7; wr_way = 3'd5; wr_tag = 21'h00777; wr_state = 2'd3;
        step();
        wr_valid = 0;
        chk("replay_hold", 64'(resp_valid), 64'd0);
        step();
        chk("replay_v", 64'(resp_valid), 64'd1);
        chk("replay_res", 64'(dut_res()), 64'(mk(1, 5, 3, 0, 1, 0)));
        step();

        // Backpressure with both stages full.
        resp_ready = 0;
        req_valid = 1; req_idx = 6'd5; req_tag = 21'h1ABCD;
        step();
        req_idx = 6'd10; req_tag = 21'h00001;
        #1 chk("bp_second_ready", 64'(req_ready), 64'd1);
        step();
        req_valid = 0;
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", 64'(resp_valid), 64'd1);
            chk("bp_hold", 64'(dut_res()), 64'(mk(1, 3, 2, 0, 1, 0)));
            chk("bp_rd_en", 64'(arr_R0_en), 64'd1);
            chk("bp_rd_addr", 64'(arr_R0_addr), 64'd10);
            chk("bp_req_ready", 64'(req_ready), 64'd0);
            step();
        end
        resp_ready = 1;
        step();
        chk("bp_second_v", 64'(resp_valid), 64'd1);
        chk("bp_second_res", 64'(dut_res()), 64'(mk(0, 0, 0, 0, 1, 0)));
        step();
        chk("bp_no_dup", 64'(resp_valid), 64'd0);

        do_write(0, 2, 21'h0AAAA, 1);
        do_write(0, 6, 21'h0AAAA, 3);
        look("multi_hit", 0, 21'h0AAAA, mk(1, 2, 1, 1, 1, 0));
        for (int w = 0; w < 8; w++) do_write(20, w, 21'(32'h100 + w), 1 + w % 3);
        look("full_set", 20, 21'h107, mk(1, 7, 2, 0, 0, 0));
        chk_perf("dir_perf");

        // Reset while a lookup is in S1.
        req_valid = 1; req_idx = 6'd5; req_tag = 21'h1ABCD;
        step();
        req_valid = 0; reset = 1;
        step();
        reset = 0;
        #1 chk("mid_rst_req_ready", 64'(req_ready), 64'd1);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("mid_rst_no_resp", 64'(resp_valid), 64'd0);
        end

        // Random traffic concentrated on a few sets and tags to provoke collisions.
        for (int i = 0; i < 400; i++) begin
            req_valid = ($urandom % 3) != 0;
            req_idx = 6'($urandom % 4);
            req_tag = 21'($urandom % 4);
            wr_valid = ($urandom % 4) == 0;
            wr_idx = 6'($urandom % 4);
            wr_way = 3'($urandom % 8);
            wr_tag = 21'($urandom % 4);
            wr_state = 2'($urandom % 4);
            resp_ready = ($urandom % 4) != 0;
            step();
        end
        drain();
        chk_perf("rand_perf");

`ifdef DCACHE_TAG_LOOKUP_PERF_EN
        reset = 1;
        step();
        reset = 0;
        req_valid = 1; req_idx = 6'd0; req_tag = 21'h0AAAA; resp_ready = 1;
        for (int i = 0; i < 70000 && n_req < (1 << CNT_W) + 1; i++) step();
        chk("wrap_issued", 64'(n_req), 64'((1 << CNT_W) + 1));
        drain();
        chk_perf("wrap_perf");
        chk("wrap_hits_one", 64'(perf_hits), 64'd1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
